// File: rtl/fp_normalizer.sv
`default_nettype none
// ============================================================================
// Module   : fp_normalizer
// Purpose  : Two-stage post-add normaliser (leading-zero detect, then shift
//            and exponent adjust) with a global pipeline enable.
// Options  : NORM_DENORMAL_EN - produce denormal fractions on underflow
//            instead of flushing them to zero.
// Revision : 1.0 - initial release
// ============================================================================
module fp_normalizer #(
    parameter int M = 23,
    parameter int E = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M+1:0] in_mant,
    input  logic [E-1:0] in_exp,
    input  logic         in_sign,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] out_frac,
    output logic [E-1:0] out_exp,
    output logic         out_sign,
    output logic         out_zero,
    output logic         out_ovf,
    output logic         out_unf
);

    localparam int           c_lz_w    = $clog2(M + 1);
    localparam int           c_xw      = E + 1;
    localparam logic [E-1:0] c_exp_max = {E{1'b1}};
    localparam logic [E-1:0] c_exp_one = E'(1);
    localparam logic [c_xw-1:0] c_xone = c_xw'(1);

    logic              w_en;
    logic [c_lz_w-1:0] w_lz;

    logic              r_s1_valid;
    logic              r_s1_carry;
    logic              r_s1_zero;
    logic              r_s1_sign;
    logic [c_lz_w-1:0] r_s1_lz;
    logic [M+1:0]      r_s1_mant;
    logic [E-1:0]      r_s1_exp;

    logic [c_xw-1:0]   w_exp_x;
    logic [c_xw-1:0]   w_lz_x;
    logic [c_xw-1:0]   w_exp_inc;
    logic [E-1:0]      w_exp_sub;
    logic [M-1:0]      w_shl;
    logic [M-1:0]      w_unf_frac;

    logic [M-1:0]      w_frac;
    logic [E-1:0]      w_exp;
    logic              w_zero;
    logic              w_ovf;
    logic              w_unf;

    logic              r_out_valid;
    logic [M-1:0]      r_out_frac;
    logic [E-1:0]      r_out_exp;
    logic              r_out_sign;
    logic              r_out_zero;
    logic              r_out_ovf;
    logic              r_out_unf;

    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = w_en;

    // Highest set bit wins; an all-zero field leaves lz at M (covered by
    // the zero and carry cases downstream).
    always_comb begin
        w_lz = c_lz_w'(M);
        for (int i = 0; i <= M; i++) begin
            if (in_mant[i]) begin
                w_lz = c_lz_w'(M - i);
            end
        end
    end

    assign w_exp_x   = {1'b0, r_s1_exp};
    assign w_lz_x    = c_xw'(r_s1_lz);
    assign w_exp_inc = w_exp_x + c_xone;
    assign w_exp_sub = r_s1_exp - E'(r_s1_lz);
    // Bits shifted past the hidden position are dropped, so the fraction
    // field alone is enough to feed the shifter.
    assign w_shl     = r_s1_mant[M-1:0] << r_s1_lz;

`ifdef NORM_DENORMAL_EN
    logic [E-1:0] w_dn_sh;

    assign w_dn_sh    = (r_s1_exp == '0) ? '0 : (r_s1_exp - c_exp_one);
    assign w_unf_frac = r_s1_mant[M-1:0] << w_dn_sh;
`else
    assign w_unf_frac = '0;
`endif

    always_comb begin
        w_frac = '0;
        w_exp  = '0;
        w_zero = 1'b0;
        w_ovf  = 1'b0;
        w_unf  = 1'b0;
        if (r_s1_zero) begin
            w_zero = 1'b1;
        end else if (r_s1_carry) begin
            if (w_exp_inc >= {1'b0, c_exp_max}) begin
                w_exp = c_exp_max;
                w_ovf = 1'b1;
            end else begin
                w_exp  = w_exp_inc[E-1:0];
                w_frac = r_s1_mant[M:1];
            end
        end else if (w_exp_x > w_lz_x) begin
            w_exp  = w_exp_sub;
            w_frac = w_shl;
        end else begin
            w_unf  = 1'b1;
            w_frac = w_unf_frac;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_carry  <= 1'b0;
            r_s1_zero   <= 1'b0;
            r_s1_sign   <= 1'b0;
            r_s1_lz     <= '0;
            r_s1_mant   <= '0;
            r_s1_exp    <= '0;
            r_out_valid <= 1'b0;
            r_out_frac  <= '0;
            r_out_exp   <= '0;
            r_out_sign  <= 1'b0;
            r_out_zero  <= 1'b0;
            r_out_ovf   <= 1'b0;
            r_out_unf   <= 1'b0;
        end else if (w_en) begin
            r_s1_valid  <= in_valid;
            r_s1_carry  <= in_mant[M+1];
            r_s1_zero   <= (in_mant == '0);
            r_s1_sign   <= in_sign;
            r_s1_lz     <= w_lz;
            r_s1_mant   <= in_mant;
            r_s1_exp    <= in_exp;
            r_out_valid <= r_s1_valid;
            r_out_frac  <= w_frac;
            r_out_exp   <= w_exp;
            r_out_sign  <= r_s1_sign;
            r_out_zero  <= w_zero;
            r_out_ovf   <= w_ovf;
            r_out_unf   <= w_unf;
        end
    end

    assign out_valid = r_out_valid;
    assign out_frac  = r_out_frac;
    assign out_exp   = r_out_exp;
    assign out_sign  = r_out_sign;
    assign out_zero  = r_out_zero;
    assign out_ovf   = r_out_ovf;
    assign out_unf   = r_out_unf;

endmodule
`default_nettype wire

// File: tb/tb_fp_normalizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_normalizer
// Purpose  : Self-checking bench for fp_normalizer: vector table, directed
//            flow-control/reset sequences and randomized model comparison.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_normalizer;

    localparam int M = 23;
    localparam int E = 8;

    typedef struct packed {
        logic [M-1:0] frac;
        logic [E-1:0] exp;
        logic         sign;
        logic         zero;
        logic         ovf;
        logic         unf;
    } res_t;

    typedef struct {
        logic [M+1:0] mant;
        logic [E-1:0] exp;
        logic         sign;
        res_t         res;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [M+1:0] in_mant;
    logic [E-1:0] in_exp;
    logic         in_sign;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] out_frac;
    logic [E-1:0] out_exp;
    logic         out_sign;
    logic         out_zero;
    logic         out_ovf;
    logic         out_unf;

    int   n_vec = 0;
    int   n_err = 0;
    res_t exp_q[$];
    vec_t tbl[12];
    res_t mon_want;
    res_t snap;
    logic [31:0]  rnd_r;
    logic [M+1:0] rnd_m;
    int   rnd_e;
    logic rnd_s;
    int   rnd_idle;
    bit   rnd_done;
    bit   dn_en;
    int   bp_wait;

    fp_normalizer #(.M(M), .E(E)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mant   (in_mant),
        .in_exp    (in_exp),
        .in_sign   (in_sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_frac  (out_frac),
        .out_exp   (out_exp),
        .out_sign  (out_sign),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    always #5 clk = ~clk;

    function automatic res_t got_res();
        return {out_frac, out_exp, out_sign, out_zero, out_ovf, out_unf};
    endfunction

    // Reference: numeric value arithmetic on the significand.
    function automatic res_t model(input logic [M+1:0] mant, input int ex, input logic sign);
        res_t   r;
        longint v;
        longint t;
        longint fmod;
        int     msb;
        int     lz;
        r      = '0;
        r.sign = sign;
        v      = longint'(mant);
        fmod   = longint'(1) << M;
        if (v == 0) begin
            r.zero = 1'b1;
        end else if (v >= (longint'(1) << (M + 1))) begin
            if (ex + 1 >= (1 << E) - 1) begin
                r.ovf = 1'b1;
                r.exp = '1;
            end else begin
                r.exp  = E'(ex + 1);
                r.frac = M'((v / 2) % fmod);
            end
        end else begin
            t   = v;
            msb = -1;
            while (t > 0) begin
                t = t / 2;
                msb++;
            end
            lz = M - msb;
            if (ex > lz) begin
                r.exp  = E'(ex - lz);
                r.frac = M'((v * (longint'(1) << lz)) % fmod);
            end else begin
                r.unf = 1'b1;
`ifdef NORM_DENORMAL_EN
                r.frac = M'((v * (longint'(1) << ((ex > 0) ? ex - 1 : 0))) % fmod);
`endif
            end
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic [M+1:0] mant, input logic [E-1:0] ex, input logic sign,
                                input logic [M-1:0] frac, input logic [E-1:0] oexp,
                                input logic zero, input logic ovf, input logic unf);
        vec_t v;
        v.mant = mant;
        v.exp  = ex;
        v.sign = sign;
        v.res  = {frac, oexp, sign, zero, ovf, unf};
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic send(input logic [M+1:0] m, input logic [E-1:0] e, input logic s,
                        input res_t want);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_mant  = m;
        in_exp   = e;
        in_sign  = s;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: in_ready=0 after %0d cycles, expected 1", waited);
        end else begin
            exp_q.push_back(want);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef NORM_DENORMAL_EN
        dn_en = 1'b1;
`else
        dn_en = 1'b0;
`endif
        tbl[0]  = mk(25'h0400000, 8'd130, 1'b0, 23'h000000, 8'd129, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(25'h1800000, 8'd127, 1'b0, 23'h400000, 8'd128, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mk(25'h1800000, 8'd254, 1'b0, 23'h000000, 8'd255, 1'b0, 1'b1, 1'b0);
        tbl[3]  = mk(25'h0000000, 8'd77,  1'b1, 23'h000000, 8'd0,   1'b1, 1'b0, 1'b0);
        tbl[4]  = mk(25'h0000001, 8'd10,  1'b0, dn_en ? 23'h000200 : 23'h0, 8'd0, 1'b0, 1'b0, 1'b1);
        tbl[5]  = mk(25'h0FFFFFF, 8'd1,   1'b0, 23'h7FFFFF, 8'd1,   1'b0, 1'b0, 1'b0);
        tbl[6]  = mk(25'h0C00000, 8'd0,   1'b1, dn_en ? 23'h400000 : 23'h0, 8'd0, 1'b0, 1'b0, 1'b1);
        tbl[7]  = mk(25'h0000001, 8'd24,  1'b0, 23'h000000, 8'd1,   1'b0, 1'b0, 1'b0);
        tbl[8]  = mk(25'h0000001, 8'd23,  1'b0, dn_en ? 23'h400000 : 23'h0, 8'd0, 1'b0, 1'b0, 1'b1);
        tbl[9]  = mk(25'h1000000, 8'd5,   1'b1, 23'h000000, 8'd6,   1'b0, 1'b0, 1'b0);
        tbl[10] = mk(25'h1FFFFFF, 8'd253, 1'b0, 23'h7FFFFF, 8'd254, 1'b0, 1'b0, 1'b0);
        tbl[11] = mk(25'h0000003, 8'd200, 1'b1, 23'h400000, 8'd178, 1'b0, 1'b0, 1'b0);

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mant   = '0;
        in_exp    = '0;
        in_sign   = 1'b0;
        out_ready = 1'b1;
        rnd_done  = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (!rst && out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_beat: got frac=%h exp=%0d, expected no beat",
                                 out_frac, out_exp);
                    end else begin
                        mon_want = exp_q.pop_front();
                        check("beat", 64'(got_res()), 64'(mon_want));
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_outputs", 64'(got_res()), 64'd0);

        // Two-cycle latency on an idle pipeline.
        exp_q.push_back(tbl[0].res);
        in_valid = 1'b1;
        in_mant  = tbl[0].mant;
        in_exp   = tbl[0].exp;
        in_sign  = tbl[0].sign;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("latency_edge1", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("latency_edge2", 64'(out_valid), 64'd1);
        drain("latency_drain");

        foreach (tbl[i]) send(tbl[i].mant, tbl[i].exp, tbl[i].sign, tbl[i].res);
        drain("table_drain");

        // Back-pressure: 3 stalled cycles right after the first output.
        fork
            begin
                for (int i = 0; i < 6; i++) send(tbl[i].mant, tbl[i].exp, tbl[i].sign, tbl[i].res);
            end
            begin
                bp_wait = 0;
                do begin
                    @(posedge clk);
                    #1;
                    bp_wait++;
                end while (!out_valid && bp_wait < 20);
                out_ready = 1'b0;
                snap = got_res();
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("bp_in_ready_low", 64'(in_ready), 64'd0);
                    check("bp_hold", 64'(got_res()), 64'(snap));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(negedge clk);
                check("bp_in_ready_release", 64'(in_ready), 64'd1);
            end
        join
        drain("bp_drain");

        // Reset with one beat in the output register and one in stage 1.
        out_ready = 1'b0;
        send(tbl[1].mant, tbl[1].exp, tbl[1].sign, tbl[1].res);
        send(tbl[5].mant, tbl[5].exp, tbl[5].sign, tbl[5].res);
        in_valid = 1'b1;
        in_mant  = tbl[9].mant;
        in_exp   = tbl[9].exp;
        in_sign  = tbl[9].sign;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        exp_q.delete();
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_outputs", 64'(got_res()), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_no_beat", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // Randomized traffic with random gaps and random back-pressure.
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    rnd_idle = int'($urandom_range(0, 2));
                    if (rnd_idle > 0) begin
                        repeat (rnd_idle) @(posedge clk);
                        #1;
                    end
                    rnd_r = $urandom;
                    rnd_m = rnd_r[M+1:0];
                    case ($urandom_range(0, 5))
                        0:       rnd_m = '0;
                        1:       rnd_m[M+1] = 1'b1;
                        default: begin
                            rnd_m[M+1] = 1'b0;
                            rnd_m = rnd_m >> $urandom_range(0, M);
                        end
                    endcase
                    rnd_e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30))
                                                        : int'($urandom_range(0, 254));
                    rnd_s = rnd_r[31];
                    send(rnd_m, E'(rnd_e), rnd_s, model(rnd_m, rnd_e, rnd_s));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain("random_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
